// File: rtl/sport0_rx_shift_pkg.sv
// Shared definitions for the SPORT receive path: word width, data-type and
// FSM state encodings used by the shifter and the justifier.
`timescale 1ns/1ps
package sport0_rx_shift_pkg;

    localparam int WMAX = 16;
    localparam int CW   = 4;

    typedef enum logic [1:0] {
        DT_ZFILL = 2'b00,
        DT_SEXT  = 2'b01,
        DT_MULAW = 2'b10,
        DT_ALAW  = 2'b11
    } dtype_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/sport_rx_justify.sv
// Combinational justifier: keeps the low SLEN+1 received bits and fills the
// upper bits with zeros or with the sign bit, depending on the data type.
`timescale 1ns/1ps
module sport_rx_justify #(
    parameter int WMAX = sport0_rx_shift_pkg::WMAX,
    parameter int CW   = sport0_rx_shift_pkg::CW
) (
    input  logic [WMAX-1:0] word,
    input  logic [CW-1:0]   slen,
    input  logic [1:0]      dtype,
    output logic [WMAX-1:0] justified
);
    import sport0_rx_shift_pkg::*;

    logic sign;

    // Companded types rely on slen=7, so the mask alone zeroes bits 15:8.
    always_comb begin
        justified = '0;
        sign      = word[slen];
        for (int i = 0; i < WMAX; i++) begin
            if (i <= int'(slen)) begin
                justified[i] = word[i];
            end else if (dtype == DT_SEXT) begin
                justified[i] = sign;
            end else begin
                justified[i] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/sport0_rx_shift.sv
// SPORT0 serial receive front end: frames and deserialises DR on SCLK_EN
// strobes, justifies the word and manages the ready / overflow flags.
`timescale 1ns/1ps
module sport0_rx_shift #(
    parameter int WMAX = sport0_rx_shift_pkg::WMAX,
    parameter int CW   = sport0_rx_shift_pkg::CW
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            SCLK_EN,
    input  logic            DR,
    input  logic            RFS,
    input  logic            RX_EN,
    input  logic            RFSR,
    input  logic [CW-1:0]   SLEN,
    input  logic [1:0]      DTYPE0,
    input  logic            RX_ACK,
    output logic [WMAX-1:0] RX,
    output logic            RX_RDY,
    output logic            RX_OVF,
    output logic            RX_BUSY
);
    import sport0_rx_shift_pkg::*;

    state_t          state_r, state_nx;
    logic [CW-1:0]   cnt_r, cnt_nx;
    logic [WMAX-1:0] shreg_r, shreg_nx;
    logic [WMAX-1:0] rx_r, rx_nx;
    logic            rdy_r, rdy_nx;
    logic            ovf_r, ovf_nx;
    logic            done_r, done_nx;
    logic            en_d_r;
    logic [WMAX-1:0] shifted;
    logic [WMAX-1:0] justified;

    assign shifted = {shreg_r[WMAX-2:0], DR};

    sport_rx_justify #(
        .WMAX (WMAX),
        .CW   (CW)
    ) u_justify (
        .word      (shifted),
        .slen      (SLEN),
        .dtype     (DTYPE0),
        .justified (justified)
    );

    // Next-state and flag logic; ack and enable handling act every cycle,
    // framing and shifting only on serial-clock strobes.
    always_comb begin
        state_nx = state_r;
        cnt_nx   = cnt_r;
        shreg_nx = shreg_r;
        rx_nx    = rx_r;
        rdy_nx   = rdy_r & ~RX_ACK;
        ovf_nx   = ovf_r;
        done_nx  = done_r;
        if (en_d_r && !RX_EN) begin
            ovf_nx = 1'b0;
        end else begin
            ovf_nx = ovf_r;
        end
        if (!RX_EN) begin
            state_nx = ST_IDLE;
            cnt_nx   = '0;
            shreg_nx = '0;
            done_nx  = 1'b0;
        end else if (SCLK_EN) begin
            case (state_r)
                ST_IDLE: begin
                    if (RFS || (!RFSR && done_r)) begin
                        state_nx = ST_SHIFT;
                        cnt_nx   = '0;
                    end else begin
                        state_nx = ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    shreg_nx = shifted;
                    if (cnt_r == SLEN) begin
                        rx_nx   = justified;
                        rdy_nx  = 1'b1;
                        done_nx = 1'b1;
                        cnt_nx  = '0;
                        if (rdy_r && !RX_ACK) begin
                            ovf_nx = 1'b1;
                        end else begin
                            ovf_nx = ovf_r;
                        end
                        if (RFS || !RFSR) begin
                            state_nx = ST_SHIFT;
                        end else begin
                            state_nx = ST_IDLE;
                        end
                    end else begin
                        cnt_nx = cnt_r + CW'(1);
                    end
                end
                default: begin
                    state_nx = ST_IDLE;
                    cnt_nx   = '0;
                end
            endcase
        end else begin
            state_nx = state_r;
        end
    end

    // State and output registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            shreg_r <= '0;
            rx_r    <= '0;
            rdy_r   <= 1'b0;
            ovf_r   <= 1'b0;
            done_r  <= 1'b0;
            en_d_r  <= 1'b0;
        end else begin
            state_r <= state_nx;
            cnt_r   <= cnt_nx;
            shreg_r <= shreg_nx;
            rx_r    <= rx_nx;
            rdy_r   <= rdy_nx;
            ovf_r   <= ovf_nx;
            done_r  <= done_nx;
            en_d_r  <= RX_EN;
        end
    end

    assign RX      = rx_r;
    assign RX_RDY  = rdy_r;
    assign RX_OVF  = ovf_r;
    assign RX_BUSY = (state_r == ST_SHIFT);

endmodule

// File: tb/tb_sport0_rx_shift.sv
// Scoreboard bench for sport0_rx_shift: directed scenarios plus random words,
// expected words queued at stimulus time and checked by a negedge monitor.
`timescale 1ns/1ps
module tb_sport0_rx_shift;

    localparam int WMAX = 16;
    localparam int CW   = 4;

    logic            CLK = 1'b0;
    logic            RST = 1'b1;
    logic            SCLK_EN = 1'b0;
    logic            DR = 1'b0;
    logic            RFS = 1'b0;
    logic            RX_EN = 1'b0;
    logic            RFSR = 1'b1;
    logic [CW-1:0]   SLEN = 4'd7;
    logic [1:0]      DTYPE0 = 2'b00;
    logic            RX_ACK = 1'b0;
    logic [WMAX-1:0] RX;
    logic            RX_RDY;
    logic            RX_OVF;
    logic            RX_BUSY;

    sport0_rx_shift #(.WMAX(WMAX), .CW(CW)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .SCLK_EN (SCLK_EN),
        .DR      (DR),
        .RFS     (RFS),
        .RX_EN   (RX_EN),
        .RFSR    (RFSR),
        .SLEN    (SLEN),
        .DTYPE0  (DTYPE0),
        .RX_ACK  (RX_ACK),
        .RX      (RX),
        .RX_RDY  (RX_RDY),
        .RX_OVF  (RX_OVF),
        .RX_BUSY (RX_BUSY)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [15:0] rx;
        logic        ovf;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    logic mdl_rdy = 1'b0;
    logic mdl_ovf = 1'b0;

    // Expected word from the received bits: keep slen+1 LSBs, optionally sign-extend.
    function automatic logic [15:0] model(input logic [15:0] bits, input int slen, input logic [1:0] dt);
        logic [15:0] mask;
        logic [15:0] v;
        mask = 16'hFFFF >> (15 - slen);
        v = bits & mask;
        if (dt == 2'b01 && bits[slen]) v = v | ~mask;
        return v;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic strobe(input logic r, input logic d, input logic a);
        SCLK_EN = 1'b1;
        RFS     = r;
        DR      = d;
        RX_ACK  = a;
        tick();
        SCLK_EN = 1'b0;
        RFS     = 1'b0;
        DR      = 1'b0;
        RX_ACK  = 1'b0;
        repeat ($urandom_range(2, 0)) tick();
    endtask

    task automatic send_word(input logic [15:0] bits, input int slen, input logic sync,
                             input logic rfs_last, input logic ack_last);
        exp_t e;
        if (sync) strobe(1'b1, 1'b0, 1'b0);
        for (int i = slen; i >= 0; i--) begin
            if (i == 0) begin
                if (mdl_rdy && !ack_last) mdl_ovf = 1'b1;
                mdl_rdy = 1'b1;
                e.rx  = model(bits, slen, DTYPE0);
                e.ovf = mdl_ovf;
                exp_q.push_back(e);
                strobe(rfs_last, bits[0], ack_last);
            end else begin
                strobe(1'b0, bits[i], 1'b0);
            end
        end
    endtask

    task automatic ack();
        RX_ACK = 1'b1;
        tick();
        RX_ACK  = 1'b0;
        mdl_rdy = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] rbits;
        int          rslen;
        logic [1:0]  rdt;

        // Monitor: a new word is a rising RX_RDY or a changed RX while ready.
        fork
            begin
                logic        prev_rdy;
                logic [15:0] prev_rx;
                exp_t        e;
                prev_rdy = 1'b0;
                prev_rx  = 16'h0000;
                forever begin
                    @(negedge CLK);
                    if (!RST && RX_RDY && (!prev_rdy || RX !== prev_rx)) begin
                        if (exp_q.size() == 0) begin
                            n_cmp++;
                            n_err++;
                            $display("FAIL unexpected_word: got %h, expected none", RX);
                        end else begin
                            e = exp_q.pop_front();
                            check("word_rx", RX, e.rx);
                            check("word_ovf", 16'(RX_OVF), 16'(e.ovf));
                        end
                    end
                    prev_rdy = RX_RDY;
                    prev_rx  = RX;
                end
            end
        join_none

        repeat (3) tick();
        check("reset_rx", RX, 16'h0000);
        check("reset_rdy", 16'(RX_RDY), 16'h0000);
        check("reset_ovf", 16'(RX_OVF), 16'h0000);
        check("reset_busy", 16'(RX_BUSY), 16'h0000);
        RST = 1'b0;
        RX_EN = 1'b1;
        tick();

        SLEN = 4'd7; DTYPE0 = 2'b00;
        send_word(16'h00B2, 7, 1'b1, 1'b0, 1'b0);
        tick();
        check("zfill_rx", RX, 16'h00B2);
        check("zfill_rdy", 16'(RX_RDY), 16'h0001);
        check("zfill_busy", 16'(RX_BUSY), 16'h0000);
        ack();
        check("ack_clears_rdy", 16'(RX_RDY), 16'h0000);

        SLEN = 4'd11; DTYPE0 = 2'b01;
        send_word(16'h09A5, 11, 1'b1, 1'b0, 1'b0);
        tick();
        check("sext_neg", RX, 16'hF9A5);
        ack();
        send_word(16'h05A5, 11, 1'b1, 1'b0, 1'b0);
        tick();
        check("sext_pos", RX, 16'h05A5);
        ack();

        SLEN = 4'd15; DTYPE0 = 2'b00;
        send_word(16'h1234, 15, 1'b1, 1'b1, 1'b0);
        send_word(16'hABCD, 15, 1'b0, 1'b0, 1'b0);
        tick();
        check("ovf_rx", RX, 16'hABCD);
        check("ovf_set", 16'(RX_OVF), 16'h0001);
        check("ovf_rdy", 16'(RX_RDY), 16'h0001);
        RX_EN = 1'b0;
        tick();
        mdl_ovf = 1'b0;
        check("ovf_cleared", 16'(RX_OVF), 16'h0000);
        check("ovf_rdy_held", 16'(RX_RDY), 16'h0001);
        check("ovf_rx_held", RX, 16'hABCD);
        RX_EN = 1'b1;
        tick();
        ack();

        RFSR = 1'b0; SLEN = 4'd7; DTYPE0 = 2'b11;
        send_word(16'h00D5, 7, 1'b1, 1'b0, 1'b0);
        ack();
        send_word(16'h002A, 7, 1'b0, 1'b0, 1'b0);
        ack();
        send_word(16'h00FF, 7, 1'b0, 1'b0, 1'b0);
        check("rfsr0_busy", 16'(RX_BUSY), 16'h0001);
        ack();
        check("rfsr0_rx", RX, 16'h00FF);
        check("rfsr0_no_ovf", 16'(RX_OVF), 16'h0000);
        RX_EN = 1'b0;
        tick();
        RFSR = 1'b1;
        RX_EN = 1'b1;
        tick();

        DTYPE0 = 2'b00;
        send_word(16'h003C, 7, 1'b1, 1'b0, 1'b0);
        send_word(16'h00C3, 7, 1'b1, 1'b0, 1'b1);
        tick();
        check("collide_rdy", 16'(RX_RDY), 16'h0001);
        check("collide_ovf", 16'(RX_OVF), 16'h0000);
        check("collide_rx", RX, 16'h00C3);
        ack();

        SLEN = 4'd15;
        strobe(1'b1, 1'b0, 1'b0);
        repeat (5) strobe(1'b0, 1'($urandom_range(1, 0)), 1'b0);
        RX_EN = 1'b0;
        tick();
        check("abort_busy", 16'(RX_BUSY), 16'h0000);
        check("abort_rx_held", RX, 16'h00C3);
        RX_EN = 1'b1;
        tick();
        send_word(16'h8001, 15, 1'b1, 1'b0, 1'b0);
        tick();
        check("abort_recover", RX, 16'h8001);
        ack();

        strobe(1'b1, 1'b0, 1'b0);
        repeat (3) strobe(1'b0, 1'b1, 1'b0);
        #2 RST = 1'b1;
        #1;
        check("areset_rx", RX, 16'h0000);
        check("areset_rdy", 16'(RX_RDY), 16'h0000);
        check("areset_busy", 16'(RX_BUSY), 16'h0000);
        mdl_rdy = 1'b0;
        mdl_ovf = 1'b0;
        tick();
        RST = 1'b0;
        tick();
        DTYPE0 = 2'b01;
        send_word(16'h4D2E, 15, 1'b1, 1'b0, 1'b0);
        tick();
        check("after_reset", RX, 16'h4D2E);
        ack();

        for (int n = 0; n < 40; n++) begin
            rdt   = 2'($urandom_range(3, 0));
            rslen = (rdt[1]) ? 7 : int'($urandom_range(15, 2));
            rbits = 16'($urandom);
            SLEN   = rslen[CW-1:0];
            DTYPE0 = rdt;
            send_word(rbits, rslen, 1'b1, 1'b0, 1'b0);
            ack();
        end

        repeat (4) tick();
        check("queue_empty", 16'(exp_q.size()), 16'h0000);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
